// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int address_width, input int sets);
        return address_width - 2 - $clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the direct-mapped cache: combinational read by index,
// single-line synchronous write, synchronous clear of every valid bit on rst.
module dcache_array #(
    parameter int SETS       = 8,
    parameter int TAG_W      = 27,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(SETS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      rd_index,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tags  [SETS];
    logic [DATA_WIDTH-1:0] datas [SETS];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = datas[rd_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tags[wr_index]  <= wr_tag;
            datas[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache between the core
// load/store path and a slower ack-based memory. Optional macro: DCACHE_STATS_EN.
//
// state | meaning
// IDLE  | serve read hits combinationally, launch misses and writes
// FETCH | read miss outstanding, fill line and return data on mem_ack
// WRITE | store outstanding, update line only if it already holds the address
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int IDX_W = index_width(SETS);
    localparam int TAG_W = tag_width(ADDRESS_WIDTH, SETS);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};

    state_t                  state, state_nx;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;

    logic [IDX_W-1:0]      cpu_index, q_index, rd_index;
    logic [TAG_W-1:0]      cpu_tag, q_tag, line_tag;
    logic                  line_valid;
    logic [DATA_WIDTH-1:0] line_data;
    logic                  hit;
    logic                  wr_en;
    logic                  fill;

    assign cpu_index = cpu_addr[2+IDX_W-1:2];
    assign cpu_tag   = cpu_addr[ADDRESS_WIDTH-1:2+IDX_W];
    assign q_index   = addr_q[2+IDX_W-1:2];
    assign q_tag     = addr_q[ADDRESS_WIDTH-1:2+IDX_W];

    // Look up with the live address in IDLE, with the captured one mid-transaction.
    assign rd_index = (state == IDLE) ? cpu_index : q_index;
    assign hit      = cpu_req & ~cpu_we & line_valid & (line_tag == cpu_tag);

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    dcache_array #(
        .SETS       (SETS),
        .TAG_W      (TAG_W),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (rd_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en & ~rst),
        .wr_index (q_index),
        .wr_tag   (q_tag),
        .wr_data  (fill ? mem_rdata : wdata_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx != IDLE) begin
                addr_q  <= cpu_addr & WORD_MASK;
                wdata_q <= cpu_wdata;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        wr_en     = 1'b0;
        fill      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        stall    = 1'b1;
                        state_nx = WRITE;
                    end else if (hit) begin
                        cpu_rdata = line_data;
                    end else begin
                        stall    = 1'b1;
                        state_nx = FETCH;
                    end
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    wr_en     = 1'b1;
                    fill      = 1'b1;
                    cpu_rdata = mem_rdata;
                    state_nx  = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    // Write-update only; a store never allocates a line.
                    wr_en    = line_valid & (line_tag == q_tag);
                    state_nx = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && cpu_req && !cpu_we) begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: per-cycle comparison against a behavioural
// cache/memory model plus directed scenarios with hand-computed literals.
module tb_dcache_dm;

    localparam int SETS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_dm #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SETS(SETS)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory contents and response latency.
    logic [31:0] mem_model [logic [31:0]];
    int          lat = 2;
    int          cnt = 0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'hA5A5_0000 ^ a;
    endfunction

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req === 1'b1) begin
                if (cnt >= lat) begin
                    mem_ack = 1'b1;
                    cnt     = 0;
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else        mem_rdata = mem_read(mem_addr);
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Behavioural cache model: which word each set holds, plus one pending transaction.
    bit          checking = 0;
    bit          m_valid [SETS];
    logic [31:0] m_tag   [SETS];
    logic [31:0] m_data  [SETS];
    bit          busy;
    bit          op_we;
    logic [31:0] op_addr, op_data;
    int          m_hits, m_misses;

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) m_valid[i] = 0;
        busy     = 0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    always @(negedge clk) begin : cmp
        int          idx, oi;
        logic [31:0] tg, ot, e_rdata;
        bit          rhit, e_stall;
        if (checking) begin
            idx  = int'((cpu_addr >> 2) % SETS);
            tg   = cpu_addr >> (2 + $clog2(SETS));
            rhit = cpu_req && !cpu_we && m_valid[idx] && (m_tag[idx] == tg);
            if (!busy) begin
                check("mem_req_idle", {31'd0, mem_req}, 32'd0);
                e_stall = cpu_req && !rhit;
                e_rdata = rhit ? m_data[idx] : 32'd0;
            end else begin
                check("mem_req_busy", {31'd0, mem_req}, 32'd1);
                check("mem_we", {31'd0, mem_we}, {31'd0, op_we});
                check("mem_addr", mem_addr, op_addr);
                if (op_we) check("mem_wdata", mem_wdata, op_data);
                e_stall = !mem_ack;
                e_rdata = (mem_ack && !op_we) ? mem_rdata : 32'd0;
            end
            check("stall", {31'd0, stall}, {31'd0, e_stall});
            check("cpu_rdata", cpu_rdata, e_rdata);
`ifdef DCACHE_STATS_EN
            check("hit_count", hit_count, m_hits);
            check("miss_count", miss_count, m_misses);
`endif
            // Advance the model to what the coming rising edge must produce.
            if (rst) begin
                model_reset();
            end else if (!busy) begin
                if (cpu_req) begin
                    if (rhit) begin
                        m_hits++;
                    end else begin
                        if (!cpu_we) m_misses++;
                        busy    = 1;
                        op_we   = cpu_we;
                        op_addr = cpu_addr & ~32'd3;
                        op_data = cpu_wdata;
                    end
                end
            end else if (mem_ack) begin
                oi = int'((op_addr >> 2) % SETS);
                ot = op_addr >> (2 + $clog2(SETS));
                if (!op_we) begin
                    m_valid[oi] = 1;
                    m_tag[oi]   = ot;
                    m_data[oi]  = mem_rdata;
                end else if (m_valid[oi] && m_tag[oi] == ot) begin
                    m_data[oi] = op_data;
                end
                busy = 0;
            end
        end
    end

    // One core access: drive, wait for stall low (bounded), report stalls and data.
    bit          seen_req;
    logic        obs_we;
    logic [31:0] obs_addr, obs_wdata;

    task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         output int stalls, output logic [31:0] rd);
        bit done;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        stalls    = 0;
        rd        = '0;
        done      = 0;
        seen_req  = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && !seen_req) begin
                seen_req  = 1;
                obs_we    = mem_we;
                obs_addr  = mem_addr;
                obs_wdata = mem_wdata;
            end
            if (stall === 1'b0) begin
                rd   = cpu_rdata;
                done = 1;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL op_timeout: stall still high after 60 cycles, addr %h", addr);
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    initial begin : main
        int          s;
        logic [31:0] d;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_model[32'h100] = 32'hDEADBEEF;
        mem_model[32'h120] = 32'h11112222;
        mem_model[32'h140] = 32'h33334444;
        mem_model[32'h200] = 32'h55556666;
        mem_model[32'h104] = 32'h77778888;

        @(posedge clk);
        #1;
        model_reset();
        checking = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);

        // Cold read miss with ack two cycles after mem_req, then a hit.
        lat = 2;
        do_op(1'b0, 32'h100, 32'h0, s, d);
        check("miss1_stalls", s, 32'd3);
        check("miss1_data", d, 32'hDEADBEEF);
        check("miss1_addr", obs_addr, 32'h100);
        do_op(1'b0, 32'h100, 32'h0, s, d);
        check("hit1_stalls", s, 32'd0);
        check("hit1_mem_req", {31'd0, seen_req}, 32'd0);
        check("hit1_data", d, 32'hDEADBEEF);
`ifdef DCACHE_STATS_EN
        check("stats_hits_1", hit_count, 32'd1);
        check("stats_miss_1", miss_count, 32'd1);
`endif

        // Conflict on set 0 evicts 0x100; byte offset must be ignored.
        do_op(1'b0, 32'h122, 32'h0, s, d);
        check("conf_stalls", s, 32'd3);
        check("conf_data", d, 32'h11112222);
        check("conf_addr", obs_addr, 32'h120);
        do_op(1'b0, 32'h100, 32'h0, s, d);
        check("evict_stalls", s, 32'd3);

        // Write hit: memory written, line updated; ack in first mem_req cycle.
        lat = 0;
        do_op(1'b1, 32'h100, 32'h12345678, s, d);
        check("wr_stalls", s, 32'd1);
        check("wr_mem_we", {31'd0, obs_we}, 32'd1);
        check("wr_mem_addr", obs_addr, 32'h100);
        check("wr_mem_wdata", obs_wdata, 32'h12345678);
        do_op(1'b0, 32'h100, 32'h0, s, d);
        check("wr_hit_stalls", s, 32'd0);
        check("wr_hit_data", d, 32'h12345678);

        // Write miss: no allocate, existing line in that set survives.
        do_op(1'b1, 32'h200, 32'hCAFEF00D, s, d);
        check("wm_addr", obs_addr, 32'h200);
        do_op(1'b0, 32'h100, 32'h0, s, d);
        check("wm_keep_stalls", s, 32'd0);
        check("wm_keep_data", d, 32'h12345678);
        do_op(1'b0, 32'h200, 32'h0, s, d);
        check("wm_read_stalls", s, 32'd1);
        check("wm_read_data", d, 32'hCAFEF00D);

        // A second set fills independently.
        do_op(1'b0, 32'h104, 32'h0, s, d);
        check("set1_miss", s, 32'd1);
        do_op(1'b0, 32'h104, 32'h0, s, d);
        check("set1_hit", s, 32'd0);
        check("set1_data", d, 32'h77778888);

        // Reset in the middle of a fetch aborts it and empties the cache.
        lat = 1;
        do_op(1'b0, 32'h100, 32'h0, s, d);
        check("refill_stalls", s, 32'd2);
        lat = 5;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h140;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_mem_req", {31'd0, mem_req}, 32'd0);
        check("abort_stall", {31'd0, stall}, 32'd0);
`ifdef DCACHE_STATS_EN
        check("stats_hits_rst", hit_count, 32'd0);
        check("stats_miss_rst", miss_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        do_op(1'b0, 32'h100, 32'h0, s, d);
        check("post_rst_stalls", s, 32'd6);
        check("post_rst_data", d, 32'h12345678);
        lat = 0;
        do_op(1'b0, 32'h104, 32'h0, s, d);
        check("post_rst_set1", s, 32'd1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dcache_dm.md
# dcache_dm

Parametrised direct-mapped, write-through, no-write-allocate data cache between the core's load/store path (ALU result as address, rs2 value as write data) and the data memory. Reads that hit return data combinationally with no stall; misses and all writes stall the core through a request/ack handshake to a slower backing memory. It replaces the direct ALU-to-data-memory connection in the pipelined core generation.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; one word per line
- SETS, 8, number of lines; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  load/store request valid
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_rdata  out  DATA_WIDTH  load data
- stall  out  1  core must hold its request stable while high
- mem_req  out  1  backing memory request, held until mem_ack
- mem_we  out  1  backing memory write
- mem_addr  out  ADDRESS_WIDTH  word-aligned address ([1:0] = 0)
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse

## Operation
- Address split: index = addr[2+log2(SETS)-1:2], tag = addr[ADDRESS_WIDTH-1:2+log2(SETS)].
- Storage per line: valid, tag, data. hit = cpu_req & ~cpu_we & valid[index] & tag match.
- FSM states IDLE, FETCH, WRITE.
- IDLE: cpu_req=0 → stall=0, no action. Read hit → cpu_rdata = line data, stall=0, stay IDLE. Read miss → stall=1, capture aligned address, go FETCH. Any write → stall=1, capture address and data, go WRITE.
- FETCH: mem_req=1, mem_we=0. On mem_ack: line ← {valid=1, tag, mem_rdata}; cpu_rdata = mem_rdata, stall=0 that cycle; go IDLE.
- WRITE: mem_req=1, mem_we=1. On mem_ack: if line valid and tag matches, line data ← captured data (write-update); miss leaves line untouched (no allocate); stall=0 that cycle; go IDLE.
- mem_ack in IDLE ignored. cpu_rdata = 0 when neither read hit nor FETCH ack.
- mem_addr/mem_wdata registered at transition out of IDLE; stable for whole transaction.

## Timing
- Reset (rst high at edge): state IDLE, all valid bits 0, mem_addr=0, mem_wdata=0; thus mem_req=0, mem_we=0 from next cycle. Reset mid-FETCH/WRITE aborts transaction; no line update even if mem_ack coincides with reset.
- Read hit: 0-cycle latency, no stall.
- Miss/write: stall in request cycle C; mem_req first high C+1; completes in ack cycle; minimum total stall 1 cycle (ack at C+1).
- Request in cycle after completion is treated fresh; the completed request is not repeated because core advances on stall=0.
- stall combinational from state, hit and mem_ack; mem_req/mem_we purely from state.

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_count, miss_count (32 bits each, in/out after mem_ack). hit_count +1 per read-hit cycle with stall=0; miss_count +1 per read miss IDLE→FETCH. Writes not counted. Wrap at 2^32. Cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package dcache_pkg: state enum (IDLE, FETCH, WRITE), index-width and tag-width functions of ADDRESS_WIDTH/SETS.
- Sub-module dcache_array: valid/tag/data arrays; combinational read by index, synchronous single-line write, synchronous clear of all valid bits on rst.

## Test plan
- SETS=8. Reset, read 0x100, memory returns 0xDEADBEEF acked 2 cycles after mem_req → stall high until ack cycle, cpu_rdata=0xDEADBEEF there; repeat read next cycle → stall=0, mem_req=0, same data.
- Read 0x100 then 0x120 (same index 0, different tag) → both miss; read 0x100 again → miss (evicted).
- After filling 0x100, write 0x12345678 to 0x100 → mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0x12345678; after ack read 0x100 hits with 0x12345678.
- Write 0xCAFEF00D to 0x200 (not cached) → memory write; subsequent read 0x200 misses.
- Fill 0x100, start miss on 0x140, assert rst for one cycle mid-FETCH → mem_req low after edge; read 0x100 then misses.
- With DCACHE_STATS_EN: scenario 1 → miss_count=1, hit_count=1; rst → both 0.
